// File: rtl/ones_mod_checker.sv
// Serial ones-count checker: residue of accepted 1-bits modulo MOD, matched against TARGET,
// in continuous or fixed-length framed mode.
module ones_mod_checker #(
  parameter int unsigned MOD       = 2,
  parameter int unsigned TARGET    = 0,
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       en,
  input  logic                                       x,
  input  logic                                       mode,
  output logic                                       y,
  output logic [((MOD > 2) ? $clog2(MOD) : 1)-1:0]   res,
  output logic [((FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1)-1:0] bit_idx,
  output logic                                       frame_done,
  output logic                                       frame_pass
);

  localparam int unsigned RES_W = (MOD > 2) ? $clog2(MOD) : 1;
  localparam int unsigned IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

  localparam logic [RES_W:0]   MOD_W    = (RES_W+1)'(MOD);
  localparam logic [RES_W-1:0] TARGET_W = RES_W'(TARGET);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  // Reject unusable parameterisations at elaboration
  if (MOD < 2) begin : g_bad_mod
    $error("ones_mod_checker: MOD must be >= 2");
  end
  if (TARGET >= MOD) begin : g_bad_target
    $error("ones_mod_checker: TARGET must be < MOD");
  end
  if (FRAME_LEN < 2) begin : g_bad_frame_len
    $error("ones_mod_checker: FRAME_LEN must be >= 2");
  end

  logic             mode_q;
  logic [RES_W-1:0] res_d;
  logic [IDX_W-1:0] idx_d;
  logic             mode_d;
  logic             done_d;
  logic             pass_d;
  logic [RES_W:0]   sum;
  logic [RES_W-1:0] res_inc;

  // res < MOD, so res + x never exceeds MOD: one conditional subtract wraps it
  always_comb begin
    sum     = {1'b0, res} + (RES_W+1)'(x);
    res_inc = res;
    if (sum >= MOD_W) begin
      res_inc = RES_W'(sum - MOD_W);
    end else begin
      res_inc = RES_W'(sum);
    end
  end

  // Next-state logic; a mode change takes priority over the bit on that edge
  always_comb begin
    res_d  = res;
    idx_d  = bit_idx;
    mode_d = mode_q;
    done_d = 1'b0;
    pass_d = frame_pass;
    if (mode != mode_q) begin
      mode_d = mode;
      res_d  = '0;
      idx_d  = '0;
    end else if (en) begin
      if (!mode_q) begin
        res_d = res_inc;
      end else if (bit_idx == LAST_IDX) begin
        pass_d = (res_inc == TARGET_W);
        done_d = 1'b1;
        res_d  = '0;
        idx_d  = '0;
      end else begin
        res_d = res_inc;
        idx_d = bit_idx + IDX_W'(1);
      end
    end
  end

  // State register; y is registered alongside res from the same next value
  always_ff @(posedge clk) begin
    if (rst) begin
      res        <= '0;
      bit_idx    <= '0;
      mode_q     <= mode;
      frame_done <= 1'b0;
      frame_pass <= 1'b0;
      y          <= (TARGET == 0);
    end else begin
      res        <= res_d;
      bit_idx    <= idx_d;
      mode_q     <= mode_d;
      frame_done <= done_d;
      frame_pass <= pass_d;
      y          <= (res_d == TARGET_W);
    end
  end

endmodule

// File: tb/tb_ones_mod_checker.sv
// Directed bench for ones_mod_checker: three parameterisations share one stimulus stream.
module tb_ones_mod_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic x = 1'b0;
  logic mode = 1'b0;

  logic       y2, y3, y5;
  logic [0:0] r2;
  logic [1:0] r3;
  logic [2:0] r5;
  logic [2:0] i2, i3, i5;
  logic       d2, d3, d5;
  logic       p2, p3, p5;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ones_mod_checker #(.MOD(2), .TARGET(0), .FRAME_LEN(8)) u2 (
    .clk(clk), .rst(rst), .en(en), .x(x), .mode(mode),
    .y(y2), .res(r2), .bit_idx(i2), .frame_done(d2), .frame_pass(p2));

  ones_mod_checker #(.MOD(3), .TARGET(1), .FRAME_LEN(8)) u3 (
    .clk(clk), .rst(rst), .en(en), .x(x), .mode(mode),
    .y(y3), .res(r3), .bit_idx(i3), .frame_done(d3), .frame_pass(p3));

  ones_mod_checker #(.MOD(5), .TARGET(0), .FRAME_LEN(8)) u5 (
    .clk(clk), .rst(rst), .en(en), .x(x), .mode(mode),
    .y(y5), .res(r5), .bit_idx(i5), .frame_done(d5), .frame_pass(p5));

  // Apply inputs after a falling edge; outputs are read at the next falling edge
  task automatic drive(input logic e, input logic b);
    en = e;
    x  = b;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic m);
    rst  = 1'b1;
    mode = m;
    drive(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    mode = 1'b0;
    drive(1'b0, 1'b0);
    total++; if (y2 !== 1'b1) begin bad++; $display("FAIL reset_y2 got=%b exp=1", y2); end
    total++; if (y3 !== 1'b0) begin bad++; $display("FAIL reset_y3 got=%b exp=0", y3); end
    total++; if (r3 !== 2'd0 || i3 !== 3'd0) begin bad++; $display("FAIL reset_state res=%0d idx=%0d exp=0/0", r3, i3); end
    total++; if (d2 !== 1'b0 || p2 !== 1'b0) begin bad++; $display("FAIL reset_frame done=%b pass=%b exp=0/0", d2, p2); end
    drive(1'b1, 1'b1);
    total++; if (y2 !== 1'b1 || r2 !== 1'd0) begin bad++; $display("FAIL reset_override y=%b res=%0d exp=1/0", y2, r2); end
    rst = 1'b0;
  endtask

  task automatic test_continuous();
    bit stream [18] = '{0,0,1,0,1,0,1,1,0,1,0,0,0,0,1,0,1,1};
    bit exp_y  [18] = '{1,1,0,0,1,1,0,1,1,0,0,0,0,0,1,1,0,1};
    do_reset(1'b0);
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, stream[i]);
      total++;
      if (y2 !== exp_y[i] || i2 !== 3'd0 || d2 !== 1'b0) begin
        bad++;
        $display("FAIL cont_y bit=%0d y=%b idx=%0d done=%b exp=%b/0/0", i, y2, i2, d2, exp_y[i]);
      end
    end
  endtask

  task automatic test_framed();
    bit stream [16] = '{0,0,1,0,1,0,1,1,0,1,0,0,0,0,1,0};
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, stream[i]);
      total++;
      if (d3 !== ((i == 7) || (i == 15))) begin
        bad++;
        $display("FAIL framed_done bit=%0d got=%b", i, d3);
      end
      if (i == 7) begin
        total++;
        if (p3 !== 1'b1 || r3 !== 2'd0 || i3 !== 3'd0 || y3 !== 1'b0) begin
          bad++;
          $display("FAIL frame1 pass=%b res=%0d idx=%0d y=%b exp=1/0/0/0", p3, r3, i3, y3);
        end
      end
      if (i == 11) begin
        total++;
        if (r3 !== 2'd1 || i3 !== 3'd4 || y3 !== 1'b1 || p3 !== 1'b1) begin
          bad++;
          $display("FAIL frame2_mid res=%0d idx=%0d y=%b pass=%b exp=1/4/1/1", r3, i3, y3, p3);
        end
      end
      if (i == 15) begin
        total++;
        if (p3 !== 1'b0 || r3 !== 2'd0 || i3 !== 3'd0) begin
          bad++;
          $display("FAIL frame2 pass=%b res=%0d idx=%0d exp=0/0/0", p3, r3, i3);
        end
      end
    end
  endtask

  task automatic test_en_gap();
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1);
      total++;
      if (i2 !== 3'd4 || r2 !== 1'd0 || d2 !== 1'b0) begin
        bad++;
        $display("FAIL gap_hold cyc=%0d idx=%0d res=%0d done=%b exp=4/0/0", i, i2, r2, d2);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1);
      total++;
      if (d2 !== (i == 3)) begin
        bad++;
        $display("FAIL gap_done acc=%0d got=%b", i + 5, d2);
      end
    end
    total++; if (p2 !== 1'b1) begin bad++; $display("FAIL gap_pass got=%b exp=1", p2); end
  endtask

  task automatic test_mode_switch();
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    total++; if (r3 !== 2'd0 || r5 !== 3'd3) begin bad++; $display("FAIL pre_switch res3=%0d res5=%0d exp=0/3", r3, r5); end
    mode = 1'b1;
    drive(1'b1, 1'b1);
    total++;
    if (r3 !== 2'd0 || i3 !== 3'd0 || r5 !== 3'd0 || i5 !== 3'd0 || r2 !== 1'd0 || d3 !== 1'b0) begin
      bad++;
      $display("FAIL switch_edge res3=%0d idx3=%0d res5=%0d idx5=%0d res2=%0d exp=0", r3, i3, r5, i5, r2);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0);
      total++;
      if (d3 !== (i == 7)) begin bad++; $display("FAIL switch_done bit=%0d got=%b", i, d3); end
    end
    total++; if (p3 !== 1'b0 || p2 !== 1'b1) begin bad++; $display("FAIL switch_pass p3=%b p2=%b exp=0/1", p3, p2); end
  endtask

  task automatic test_rst_mid_frame();
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0);
    total++; if (p2 !== 1'b1) begin bad++; $display("FAIL pre_rst_pass got=%b exp=1", p2); end
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
    total++; if (i2 !== 3'd5 || r2 !== 1'd1) begin bad++; $display("FAIL pre_rst idx=%0d res=%0d exp=5/1", i2, r2); end
    rst = 1'b1;
    drive(1'b1, 1'b1);
    rst = 1'b0;
    total++;
    if (r2 !== 1'd0 || i2 !== 3'd0 || d2 !== 1'b0 || p2 !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst res=%0d idx=%0d done=%b pass=%b exp=0/0/0/0", r2, i2, d2, p2);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i < 2) ? 1'b1 : 1'b0);
      total++;
      if (d2 !== (i == 7)) begin bad++; $display("FAIL post_rst_done bit=%0d got=%b", i, d2); end
    end
    total++; if (p2 !== 1'b1) begin bad++; $display("FAIL post_rst_pass got=%b exp=1", p2); end
  endtask

  task automatic test_mod5_wrap();
    logic [2:0] exp_res [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1);
      total++;
      if (r5 !== exp_res[i] || y5 !== (i == 4) || d5 !== 1'b0) begin
        bad++;
        $display("FAIL mod5 one=%0d res=%0d y=%b exp=%0d/%b", i + 1, r5, y5, exp_res[i], (i == 4));
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_continuous();
    test_framed();
    test_en_gap();
    test_mode_switch();
    test_rst_mid_frame();
    test_mod5_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
